// File: rtl/fifo_ctrl_pkg.sv
// Shared state encoding and constants for the sample-FIFO read controller.
package fifo_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int UNDERRUN_W = 16;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Register-based skid FIFO that absorbs the FIFO read latency; head entry is
// presented combinationally and stays put until popped.
module rd_skid_buf
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  localparam int PW = ptrWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_doPop  = i_pop & (r_count != '0);
  assign w_doPush = i_push & (!w_full | w_doPop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (w_doPop) r_rdPtr <= nextPtr(r_rdPtr);
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Credit-based dequeue scheduler for the sample FIFO with run/drain control.
// Optional underrun counter enabled by defining FIFO_RD_UNDERRUN_CNT_EN.
module fifo_read_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int LATENCY    = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_deq,
  input  logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_valid,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int SW = CW + 1;

  if (SKID_DEPTH < LATENCY + 1) begin : g_badDepth
    $error("fifo_read_ctrl: SKID_DEPTH must be at least LATENCY+1");
  end

  logic [1:0]    r_state;
  logic [1:0]    w_stateNext;
  logic [CW-1:0] r_inFlight;
  logic [CW-1:0] w_count;
  logic [SW-1:0] w_credits;
  logic          w_push;
  logic          w_pop;
  logic          r_protocolErr;

  // A read may only be issued if its data is guaranteed a free skid slot.
  assign w_credits = SW'(w_count) + SW'(r_inFlight);
  assign fifo_deq  = (r_state == RUN) & !fifo_empty & (w_credits < SW'(SKID_DEPTH));
  assign w_push    = fifo_valid & (r_inFlight != '0);
  assign w_pop     = m_valid & m_ready;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (enable) w_stateNext = RUN;
      RUN:     if (!enable) w_stateNext = DRAIN;
      DRAIN: begin
        if (enable)                  w_stateNext = RUN;
        else if (r_inFlight == '0)   w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_inFlight    <= '0;
      r_protocolErr <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (fifo_deq && !w_push)      r_inFlight <= r_inFlight + 1'b1;
      else if (w_push && !fifo_deq) r_inFlight <= r_inFlight - 1'b1;
      if (fifo_valid && (r_inFlight == '0)) r_protocolErr <= 1'b1;
    end
  end

  assign protocol_err = r_protocolErr;

  rd_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH),
    .CW    (CW)
  ) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (fifo_data),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_valid (m_valid),
    .o_count (w_count)
  );

`ifdef FIFO_RD_UNDERRUN_CNT_EN
  logic [UNDERRUN_W-1:0] r_underrun;

  // Consumer starved while running; saturates rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= '0;
    end else if ((r_state == RUN) && m_ready && !m_valid && (r_underrun != '1)) begin
      r_underrun <= r_underrun + 1'b1;
    end
  end

  assign underrun_count = r_underrun;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: a behavioural FIFO with fixed read
// latency feeds the DUT; a monitor checks every presented sample in order.
module tb_fifo_read_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int WIDTH      = 12;
  localparam int LATENCY    = 2;
  localparam int SKID_DEPTH = 4;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_deq;
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_valid;
  logic [WIDTH-1:0]      m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;
  logic                  protocol_err;
  logic [UNDERRUN_W-1:0] underrun_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] srcQ [$];
  logic [WIDTH-1:0] skidQ [$];
  logic             pipeV [LATENCY];
  logic [WIDTH-1:0] pipeD [LATENCY];
  int               inFlightModel;
  logic             deqSeen;
  logic             drvReal;
  logic [WIDTH-1:0] drvData;
  logic             forceValid;
  logic [WIDTH-1:0] forceData;

  always #5 clock = ~clock;

  fifo_read_ctrl #(
    .WIDTH      (WIDTH),
    .LATENCY    (LATENCY),
    .SKID_DEPTH (SKID_DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_deq       (fifo_deq),
    .fifo_data      (fifo_data),
    .fifo_valid     (fifo_valid),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .busy           (busy),
    .protocol_err   (protocol_err),
    .underrun_count (underrun_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sampleCycle();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable  = en;
    m_ready = rdy;
  endtask

  task automatic loadFifo(input int first, input int n);
    for (int i = 0; i < n; i++) srcQ.push_back(WIDTH'(first + i));
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    srcQ.delete();
    repeat (2) nextCycle();
    reset_n = 1'b1;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while ((busy || m_valid) && n < limit) begin
      sampleCycle();
      n++;
    end
    checkOutput("idle_reached", {30'd0, busy, m_valid}, 32'd0);
    nextCycle();
  endtask

  // Behavioural FIFO: a dequeue seen in a cycle returns its data LATENCY cycles later.
  initial begin
    logic             newV;
    logic [WIDTH-1:0] newD;
    fifo_valid = 1'b0; fifo_data = '0; fifo_empty = 1'b1;
    drvReal = 1'b0; drvData = '0; inFlightModel = 0;
    forceValid = 1'b0; forceData = '0;
    for (int k = 0; k < LATENCY; k++) begin pipeV[k] = 1'b0; pipeD[k] = '0; end
    forever begin
      @(posedge clock);
      #2;
      if (!reset_n) begin
        srcQ.delete(); skidQ.delete();
        inFlightModel = 0; drvReal = 1'b0; forceValid = 1'b0;
        for (int k = 0; k < LATENCY; k++) pipeV[k] = 1'b0;
        fifo_valid = 1'b0; fifo_empty = 1'b1;
      end else begin
        if (drvReal) begin
          skidQ.push_back(drvData);
          inFlightModel--;
        end
        newV = deqSeen;
        newD = '0;
        if (deqSeen) begin
          checkOutput("deq_nonempty", srcQ.size() != 0, 32'd1);
          if (srcQ.size() != 0) newD = srcQ.pop_front();
          inFlightModel++;
        end
        for (int k = LATENCY - 1; k > 0; k--) begin
          pipeV[k] = pipeV[k-1];
          pipeD[k] = pipeD[k-1];
        end
        pipeV[0] = newV;
        pipeD[0] = newD;
        drvReal    = pipeV[LATENCY-1];
        drvData    = pipeD[LATENCY-1];
        fifo_valid = drvReal | forceValid;
        fifo_data  = drvReal ? drvData : forceData;
        forceValid = 1'b0;
        fifo_empty = (srcQ.size() == 0);
      end
    end
  end

  // Monitor: compares presented samples against the landed-data scoreboard.
  initial begin
    deqSeen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        deqSeen = fifo_deq;
        checkOutput("m_valid", m_valid, skidQ.size() != 0);
        checkOutput("credit", (skidQ.size() + inFlightModel) <= SKID_DEPTH, 32'd1);
        if (m_valid && skidQ.size() != 0) begin
          checkOutput("m_data", m_data, skidQ[0]);
          if (m_ready) void'(skidQ.pop_front());
        end
      end else begin
        deqSeen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int deqN, popN, firstDeq, lastDeq, firstPop, lastPop, firstValid;
    int zeroC, fallC;
    logic found;
    int expUnderrun;

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) nextCycle();
    checkOutput("rst_m_valid", m_valid, 32'd0);
    checkOutput("rst_fifo_deq", fifo_deq, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_protocol_err", protocol_err, 32'd0);
    checkOutput("rst_underrun", underrun_count, 32'd0);
    reset_n = 1'b1;

    // Streaming: 8 preloaded samples at full rate.
    nextCycle();
    loadFifo(1, 8);
    applyStimulus(1'b1, 1'b1);
    deqN = 0; popN = 0; firstDeq = -1; lastDeq = -1; firstPop = -1; lastPop = -1; firstValid = -1;
    for (int c = 0; c < 20; c++) begin
      sampleCycle();
      if (fifo_deq) begin deqN++; if (firstDeq < 0) firstDeq = c; lastDeq = c; end
      if (m_valid && m_ready) begin popN++; if (firstPop < 0) firstPop = c; lastPop = c; end
      if (m_valid && firstValid < 0) firstValid = c;
    end
    checkOutput("s1_deq_count", deqN, 32'd8);
    checkOutput("s1_pop_count", popN, 32'd8);
    checkOutput("s1_first_latency", firstValid - firstDeq, LATENCY + 1);
    checkOutput("s1_deq_span", lastDeq - firstDeq, 32'd7);
    checkOutput("s1_pop_span", lastPop - firstPop, 32'd7);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle(50);

    // Backpressure: credits stop issue at SKID_DEPTH outstanding.
    loadFifo('h101, 10);
    applyStimulus(1'b1, 1'b0);
    deqN = 0; popN = 0;
    for (int c = 0; c < 20; c++) begin
      sampleCycle();
      if (fifo_deq) deqN++;
      if (m_valid && m_ready) popN++;
    end
    checkOutput("s2_stalled_deq", deqN, SKID_DEPTH);
    checkOutput("s2_stalled_pop", popN, 32'd0);
    checkOutput("s2_stalled_valid", m_valid, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1);
    deqN = 0; popN = 0;
    for (int c = 0; c < 30; c++) begin
      sampleCycle();
      if (fifo_deq) deqN++;
      if (m_valid && m_ready) popN++;
    end
    checkOutput("s2_resume_deq", deqN, 10 - SKID_DEPTH);
    checkOutput("s2_resume_pop", popN, 32'd10);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle(50);

    // Drain with two reads outstanding.
    loadFifo('h201, 5);
    applyStimulus(1'b1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      sampleCycle();
      if (fifo_deq) found = 1'b1;
    end
    checkOutput("s3_first_deq", found, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    deqN = 0; popN = 0; zeroC = -1; fallC = -1;
    for (int c = 0; c < 20; c++) begin
      sampleCycle();
      if (fifo_deq) deqN++;
      if (m_valid && m_ready) popN++;
      if (inFlightModel == 0 && zeroC < 0) zeroC = c;
      if (!busy) begin fallC = c; break; end
    end
    checkOutput("s3_drain_deq", deqN + 1, 32'd2);
    checkOutput("s3_drain_pop", popN, 32'd2);
    checkOutput("s3_idle_delay", fallC - zeroC, 32'd1);
    nextCycle();
    srcQ.delete();

    // Underrun: RUN with an empty FIFO and a ready consumer.
    applyReset();
    applyStimulus(1'b1, 1'b1);
    repeat (20) nextCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (3) nextCycle();
`ifdef FIFO_RD_UNDERRUN_CNT_EN
    expUnderrun = 20;
`else
    expUnderrun = 0;
`endif
    checkOutput("s4_underrun", underrun_count, expUnderrun);
`ifdef FIFO_RD_UNDERRUN_CNT_EN
    force dut.r_underrun = 16'hFFFD;
    nextCycle();
    release dut.r_underrun;
    applyStimulus(1'b1, 1'b1);
    repeat (8) nextCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (3) nextCycle();
    checkOutput("s4_saturate", underrun_count, 32'hFFFF);
`endif

    // Asynchronous reset in the middle of a stream.
    loadFifo('h301, 10);
    applyStimulus(1'b1, 1'b1);
    repeat (6) nextCycle();
    checkOutput("s5_pre_valid", m_valid, 32'd1);
    checkOutput("s5_pre_busy", busy, 32'd1);
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("s5_rst_m_valid", m_valid, 32'd0);
    checkOutput("s5_rst_fifo_deq", fifo_deq, 32'd0);
    checkOutput("s5_rst_busy", busy, 32'd0);
    checkOutput("s5_rst_underrun", underrun_count, 32'd0);
    repeat (2) nextCycle();
    reset_n = 1'b1;

    // Spurious fifo_valid with nothing outstanding.
    forceData  = 12'hABC;
    forceValid = 1'b1;
    repeat (3) nextCycle();
    checkOutput("s6_protocol_err", protocol_err, 32'd1);
    checkOutput("s6_no_push", m_valid, 32'd0);
    repeat (5) nextCycle();
    checkOutput("s6_sticky", protocol_err, 32'd1);
    applyReset();
    checkOutput("s6_cleared", protocol_err, 32'd0);

    // Randomised traffic with random backpressure and enable toggling.
    loadFifo('h400, 40);
    for (int c = 0; c < 300; c++) begin
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 15) == 0) loadFifo(int'($urandom_range(0, 4095)), 3);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1);
    waitIdle(100);
    checkOutput("rand_scoreboard_empty", skidQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Dequeue scheduler for the sample FIFO (fixed LATENCY-cycle read, data_valid-tagged output). It issues dequeue pulses only when a landing slot is guaranteed, absorbs the read latency in a small skid buffer, and presents samples to a downstream consumer over valid/ready. It sits between the sample FIFO and the pitch-shift datapath and provides run/drain control plus underrun monitoring.

Parameters:
WIDTH, 12, sample width in bits
LATENCY, 2, FIFO dequeue-to-data_valid latency in cycles
SKID_DEPTH, 4, skid buffer entries; must be >= LATENCY+1 (elaboration error otherwise)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run, 0 = stop issuing and drain
fifo_empty  in  1  FIFO empty flag
fifo_deq  out  1  dequeue pulse to FIFO
fifo_data  in  WIDTH  FIFO read data
fifo_valid  in  1  FIFO data_valid
m_data  out  WIDTH  sample to consumer
m_valid  out  1  skid buffer non-empty
m_ready  in  1  consumer accepts when m_valid & m_ready
busy  out  1  state != IDLE
protocol_err  out  1  sticky: fifo_valid seen with in_flight == 0
underrun_count  out  16  see Optional Feature

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset (async assert, sync release): state=IDLE, skid count=0, in_flight=0, fifo_deq=0, m_valid=0, m_data=0, busy=0, protocol_err=0, underrun_count=0.
- States: IDLE -> RUN when enable=1. RUN -> DRAIN when enable=0. DRAIN -> RUN when enable=1. DRAIN -> IDLE when in_flight==0 (same cycle check, registered transition).
- fifo_deq (combinational from registered state): state==RUN & !fifo_empty & (count + in_flight < SKID_DEPTH). Never asserted in IDLE/DRAIN.
- in_flight counter, width $clog2(SKID_DEPTH+1): +1 on fifo_deq, -1 on fifo_valid, both in same cycle = hold.
- Skid buffer: pushes fifo_data on fifo_valid (when in_flight>0); pops on m_valid & m_ready; simultaneous push/pop keeps count, order preserved. Credit rule guarantees no push while full; bench asserts this.
- m_data = head entry; m_valid = count!=0; stable while m_valid & !m_ready.
- Throughput: 1 sample/cycle steady state with m_ready=1. First m_valid = LATENCY+1 cycles after the first fifo_deq cycle (deq at t, fifo_valid at t+LATENCY, m_valid at t+LATENCY+1).
- Skid contents persist through DRAIN and IDLE; consumer may keep popping.
- fifo_valid with in_flight==0: data dropped, protocol_err set until reset.
- FIFO and this block share the reset event; mid-operation reset discards in-flight data.

Optional Feature:
Macro FIFO_RD_UNDERRUN_CNT_EN.
- Defined: underrun_count +1 every cycle with state==RUN & m_ready & !m_valid; saturates at 16'hFFFF; cleared only by reset.
- Undefined: underrun_count tied to 0, no counter logic.

Decomposition:
- Package fifo_ctrl_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), UNDERRUN_W=16 constant.
- One sub-module: rd_skid_buf (register-based FIFO, WIDTH x SKID_DEPTH, push/pop/count/head); controller FSM and credit logic stay in fifo_read_ctrl.

Test Plan:
- Reset, FIFO preloaded with 8 samples 0x001..0x008, enable=1, m_ready=1 -> fifo_deq pulses 8 cycles, m_data 0x001..0x008 in order on consecutive cycles, first m_valid 3 cycles after first fifo_deq.
- enable=1, m_ready=0, FIFO holding 10 samples -> exactly 4 fifo_deq pulses, count=4, no further deq; m_ready=1 -> deq resumes, all 10 delivered in order.
- In RUN with 2 reads in flight, drop enable -> DRAIN, no fifo_deq, both samples land, IDLE 1 cycle after in_flight==0, busy falls.
- RUN, FIFO empty, m_ready=1 for 20 cycles -> underrun_count=20 (macro defined) / 0 (undefined); forced preset near max saturates at 0xFFFF.
- Assert reset_n=0 mid-stream -> m_valid, fifo_deq, busy low immediately (no clock edge), counters 0.
- Pulse fifo_valid with in_flight==0 -> no skid push, m_valid stays 0, protocol_err=1 until reset.
